// File: rtl/booth4_seq_mult.sv
// booth4_seq_mult: sequential radix-4 Booth signed multiplier, N/2 add/shift steps per product
module booth4_seq_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int H  = N + 2;
  localparam int CW = $clog2(N / 2);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0]   m;
  logic [N:0]     q;
  logic [H-1:0]   acc_hi;
  logic [N-1:0]   acc_lo;
  logic [CW-1:0]  cnt;
  logic           neg, two, zero, last, load;
  logic [H-1:0]   mx, mag, op, sum;
  logic [H+N-1:0] wide;
  // Booth digit decode of the low group of q (q[0] is the implicit Q[-1]) and one add/shift step
  always_comb begin
    neg  = q[2] & ~(q[1] & q[0]);
    zero = (q[2:0] == 3'b000) | (q[2:0] == 3'b111);
    two  = (q[2:0] == 3'b011) | (q[2:0] == 3'b100);
    mx   = {{2{m[N-1]}}, m};
    mag  = two ? mx << 1 : mx;
    op   = zero ? '0 : neg ? ~mag : mag;
    sum  = acc_hi + op + H'(neg);
    wide = $signed({sum, acc_lo}) >>> 2;
    last = cnt == CW'(N / 2 - 1);
    load = start && state != RUN;
  end
  // next-state and status outputs; DONE accepts a new start for back-to-back operation
  always_comb begin
    state_n = state;
    busy    = state == RUN;
    done    = state == DONE;
    case (state)
      IDLE:    state_n = start ? RUN : IDLE;
      RUN:     state_n = last ? DONE : RUN;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  // operand capture, accumulator steps and product update on the final step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m       <= '0;
      q       <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (load) begin
      m      <= multiplicand;
      q      <= {multiplier, 1'b0};
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc_hi <= wide[H+N-1:N];
      acc_lo <= wide[N-1:0];
      q      <= {2'b00, q[N:2]};
      cnt    <= cnt + 1'b1;
      if (last) product <= wide[2*N-1:0];
    end
  end
endmodule

// File: tb/tb_booth4_seq_mult.sv
// tb_booth4_seq_mult: directed scoreboard bench for booth4_seq_mult
module tb_booth4_seq_mult;
  localparam int N = 8;
  logic           clk = 0;
  logic           rst_n, start, busy, done;
  logic [N-1:0]   mc, mp;
  logic [2*N-1:0] product, last_prod;
  logic [2*N-1:0] exp_q[$];
  int checks = 0, errors = 0, dones = 0;

  booth4_seq_mult #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .multiplicand(mc), .multiplier(mp),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  task automatic push(input int m, input int q);
    exp_q.push_back((2*N)'(m * q));
  endtask

  // scoreboard: compare product on each done pulse, otherwise product must hold
  always @(negedge clk) begin
    logic [2*N-1:0] e;
    if (!rst_n) last_prod = '0;
    else begin
      chk("busy_and_done", {31'd0, busy & done}, 32'd0);
      if (done) begin
        dones++;
        chk("done_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("product", {16'd0, product}, {16'd0, e});
        end
        last_prod = product;
      end else chk("product_hold", {16'd0, product}, {16'd0, last_prod});
    end
  end

  task automatic run(input int m, input int q);
    @(negedge clk);
    mc = N'(m);
    mp = N'(q);
    start = 1;
    push(m, q);
    @(negedge clk);
    start = 0;
    for (int i = 0; i < N / 2; i++) begin
      chk("run_busy", {31'd0, busy}, 32'd1);
      chk("run_nodone", {31'd0, done}, 32'd0);
      if (i < N / 2 - 1) @(negedge clk);
    end
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    start = 0;
    mc = '0;
    mp = '0;
    rst_n = 1;
    #2 rst_n = 0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", {16'd0, product}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    run(3, 5);
    run(-128, -128);
    run(-128, 127);
    run(127, 127);
    run(0, -77);
    run(-1, -1);
    run(7, -3);
    // start during RUN is ignored
    @(negedge clk);
    mc = 8'd10;
    mp = 8'd10;
    start = 1;
    push(10, 10);
    @(negedge clk);
    start = 0;
    chk("ign_busy1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    mc = 8'd2;
    mp = 8'd2;
    start = 1;
    @(negedge clk);
    start = 0;
    chk("ign_busy3", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("ign_busy4", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("ign_done", {31'd0, done}, 32'd1);
    repeat (6) begin
      @(negedge clk);
      chk("ign_no_second_done", {31'd0, done}, 32'd0);
    end
    // start held high: back-to-back every N/2+1 cycles
    @(negedge clk);
    mc = 8'd6;
    mp = -8'sd4;
    start = 1;
    push(6, -4);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N / 2; i++) begin
        @(negedge clk);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_nodone", {31'd0, done}, 32'd0);
      end
      @(negedge clk);
      chk("b2b_done", {31'd0, done}, 32'd1);
      chk("b2b_notbusy", {31'd0, busy}, 32'd0);
      if (r < 2) push(6, -4);
      else start = 0;
    end
    @(negedge clk);
    chk("b2b_idle", {31'd0, busy | done}, 32'd0);
    // asynchronous reset aborts a running multiplication
    @(negedge clk);
    mc = 8'd9;
    mp = 8'd9;
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_product", {16'd0, product}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    run(9, 9);
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("done_count", dones, 32'd12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
